// File: rtl/ifetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifetch_unit_if : memory request port and decode handoff port bundle   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
interface ifetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              id_valid_o;
  logic              id_ready_i;
  logic [DATA_W-1:0] id_inst_o;
  logic [ADDR_W-1:0] id_pc_o;

  modport master (
    output mem_req_o, mem_addr_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output id_valid_o, id_inst_o, id_pc_o,
    input  id_ready_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  id_valid_o, id_inst_o, id_pc_o,
    output id_ready_i
  );
endinterface
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifetch_unit : one-outstanding instruction fetch between PC and decode |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module ifetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_INST = 32'h0000_0013
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic [ADDR_W-1:0] pc_i,
  input  wire logic              flush_i,
  output logic                   stall_o,
  ifetch_unit_if.master          bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t            state_q;
  logic              kill_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              id_valid_q;
  logic [DATA_W-1:0] id_inst_q;
  logic [ADDR_W-1:0] id_pc_q;

  // PC may only move on a jump or when decode takes the held instruction.
  assign stall_o = ~(flush_i | ((state_q == S_HOLD) & bus.id_ready_i));

  assign bus.mem_req_o  = mem_req_q;
  assign bus.mem_addr_o = mem_addr_q;
  assign bus.id_valid_o = id_valid_q;
  assign bus.id_inst_o  = id_inst_q;
  assign bus.id_pc_o    = id_pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      kill_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      id_valid_q <= 1'b0;
      id_inst_q  <= NOP_INST;
      id_pc_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!flush_i) begin
            mem_addr_q <= pc_i;
            mem_req_q  <= 1'b1;
            state_q    <= S_REQ;
          end
        end
        S_REQ: begin
          // The request is never withdrawn; a jump only marks its response as stale.
          if (flush_i) kill_q <= 1'b1;
          if (bus.mem_gnt_i) begin
            mem_req_q <= 1'b0;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.mem_rvalid_i) begin
            if (kill_q || flush_i) begin
              kill_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              id_inst_q  <= bus.mem_rdata_i;
              id_pc_q    <= mem_addr_q;
              id_valid_q <= 1'b1;
              state_q    <= S_HOLD;
            end
          end else if (flush_i) begin
            kill_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (flush_i || bus.id_ready_i) begin
            id_valid_q <= 1'b0;
            id_inst_q  <= NOP_INST;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
